ym3438_mixer: RTL
=================

YM3438_MIXER -- requirements
Module: ym3438_mixer

Interface
REQ-001 SHALL have parameter CH_NUM, default 6, meaning the maximum number of channel samples accumulated per frame.
REQ-002 SHALL have parameter OUT_WIDTH, default 12, meaning the signed width of each stereo output; it SHALL be at least 9+ceil(log2(CH_NUM)).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port MCLK  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port c1  input  1  slot-advance enable; state changes only in MCLK cycles where c1=1, except reset and the out_valid clear.
REQ-007 Port frame_sync  input  1  marks the first slot of a new sample frame.
REQ-008 Port ch_valid  input  1  the current slot carries a channel sample.
REQ-009 Port ch_out  input  9  channel sample in offset binary (0x100 = zero).
REQ-010 Port ch_pan  input  2  bit1 enables left, bit0 enables right.
REQ-011 Port out_l, out_r  output  OUT_WIDTH  signed two's-complement frame sums.
REQ-012 Port out_valid  output  1  one-MCLK pulse when out_l/out_r update.
REQ-013 Port frame_ovf  output  1  the latched frame held more than CH_NUM valid samples.

Function
REQ-014 SHALL convert the sample as s = {~ch_out[8], ch_out[7:0]}, signed 9-bit, sign-extended to OUT_WIDTH.
REQ-015 A slot SHALL contribute when c1=1, ch_valid=1 and the channel counter is below CH_NUM.
REQ-016 A contributing slot SHALL add s to the left accumulator when ch_pan[1]=1 and to the right accumulator when ch_pan[0]=1; otherwise it adds 0.
REQ-017 The channel counter (width ceil(log2(CH_NUM+1))) SHALL increment on each contributing slot and saturate at CH_NUM.
REQ-018 A slot with c1=1, ch_valid=1 and counter==CH_NUM SHALL NOT be accumulated and SHALL set the internal overrun bit.
REQ-019 On c1=1 with frame_sync=1, the block SHALL, in that same edge:
  - load out_l, out_r and frame_ovf from the accumulators and the overrun bit as they stood before this slot;
  - restart the accumulators, counter and overrun bit with this slot's contribution only.
REQ-020 When frame_sync and ch_valid are both 1, the slot SHALL belong to the new frame: counter becomes 1 and the accumulators hold that slot's contribution.
REQ-021 out_valid SHALL be 1 for exactly the one MCLK cycle following a c1&frame_sync edge, and 0 otherwise.
REQ-022 Latency SHALL be one MCLK cycle from the frame_sync edge to updated outputs.
REQ-023 out_l, out_r and frame_ovf SHALL hold their values between updates.
REQ-024 Accumulation SHALL be non-saturating; at the parameter minimum from REQ-002 no overflow is possible, since the range is -1536..+1530 for CH_NUM=6.
REQ-025 A frame_sync with no preceding valid slots SHALL output zeros.
REQ-026 Inputs in cycles with c1=0 SHALL be ignored.

Reset
REQ-027 While reset_n=0, out_l, out_r, out_valid, frame_ovf, the accumulators, the counter and the overrun bit SHALL be 0, asynchronously.
REQ-028 After reset_n is released mid-frame, accumulation SHALL resume from zero; the first frame_sync SHALL output only the post-reset slots.

Structure
REQ-029 Shared package ym3438_mix_pkg SHALL hold the CH_NUM default, the OUT_WIDTH default, and the offset-binary zero constant 9'h100.
REQ-030 There SHALL be one sub-module, ym3438_mix_acc: a single-side signed accumulator with enable, restart and load inputs, instantiated twice (left and right).
REQ-031 There SHALL be no other hierarchy.

Verification
REQ-032 Six valid slots, ch_out=0x1FF, pan=11, then frame_sync -> out_l=out_r=1530, frame_ovf=0, out_valid pulse one cycle.
REQ-033 Six valid slots, ch_out=0x000, pan=10, then sync -> out_l=-1536, out_r=0.
REQ-034 Seven valid slots, ch_out=0x101 each, pan=11 -> out_l=out_r=6, frame_ovf=1; next clean frame -> frame_ovf=0.
REQ-035 Same cycle carries frame_sync, ch_valid, ch_out=0x180, pan=01; no further slots; next sync -> previous frame output first, then out_r=128, out_l=0.
REQ-036 reset_n pulsed low after three slots of 0x1FF pan=11, then two slots of 0x110, then sync -> out_l=out_r=32 (two slots of +16); all outputs 0 during reset.
REQ-037 ch_valid=1 held with c1=0 for 10 cycles, then sync -> out_l=out_r=0.

Source files
------------

// File: rtl/ym3438_mix_pkg.sv
// Shared constants for the YM3438 stereo channel mixer.
package ym3438_mix_pkg;
    localparam int         CH_NUM_DEF    = 6;
    localparam int         OUT_WIDTH_DEF = 12;
    localparam logic [8:0] OFFSET_ZERO   = 9'h100;
endpackage

// File: rtl/ym3438_mix_acc.sv
// One side (left or right) of the mixer: running signed sum plus a held frame result.
module ym3438_mix_acc #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         restart,
    input  logic         load,
    input  logic         add,
    input  logic [W-1:0] sample,
    output logic [W-1:0] sum
);
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] contrib;

    always_comb begin
        contrib = add ? sample : '0;
        acc_d   = acc_q;
        out_d   = out_q;
        if (en) begin
            // The result register captures the sum as it stood before this slot.
            if (load) out_d = acc_q;
            acc_d = restart ? contrib : acc_q + contrib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign sum = out_q;
endmodule

// File: rtl/ym3438_mixer.sv
// Accumulates up to CH_NUM panned channel samples per frame and emits stereo sums on frame_sync.
module ym3438_mixer
    import ym3438_mix_pkg::*;
#(
    parameter int CH_NUM    = CH_NUM_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 MCLK,
    input  logic                 reset_n,
    input  logic                 c1,
    input  logic                 frame_sync,
    input  logic                 ch_valid,
    input  logic [8:0]           ch_out,
    input  logic [1:0]           ch_pan,
    output logic [OUT_WIDTH-1:0] out_l,
    output logic [OUT_WIDTH-1:0] out_r,
    output logic                 out_valid,
    output logic                 frame_ovf
);
    localparam int             CW     = $clog2(CH_NUM + 1);
    localparam logic [CW-1:0]  CH_MAX = CW'(CH_NUM);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 sync;
    logic                 contrib;
    logic [8:0]           s9;
    logic [OUT_WIDTH-1:0] sample;

    assign s9     = ch_out ^ OFFSET_ZERO;
    assign sample = OUT_WIDTH'($signed(s9));
    assign sync   = c1 & frame_sync;
    // A sync slot starts a fresh frame, so its own sample always fits.
    assign contrib = c1 & ch_valid & (frame_sync | (cnt_q < CH_MAX));

    always_comb begin
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        ovf_d   = ovf_q;
        valid_d = sync;
        if (c1) begin
            if (frame_sync) begin
                ovf_d = ovr_q;
                ovr_d = 1'b0;
                cnt_d = contrib ? CW'(1) : '0;
            end else if (ch_valid) begin
                if (cnt_q == CH_MAX) ovr_d = 1'b1;
                else                 cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    ym3438_mix_acc #(.W(OUT_WIDTH)) u_acc_l (
        .clk     (MCLK),
        .rst_n   (reset_n),
        .en      (c1),
        .restart (frame_sync),
        .load    (frame_sync),
        .add     (contrib & ch_pan[1]),
        .sample  (sample),
        .sum     (out_l)
    );

    ym3438_mix_acc #(.W(OUT_WIDTH)) u_acc_r (
        .clk     (MCLK),
        .rst_n   (reset_n),
        .en      (c1),
        .restart (frame_sync),
        .load    (frame_sync),
        .add     (contrib & ch_pan[0]),
        .sample  (sample),
        .sum     (out_r)
    );

    assign out_valid = valid_q;
    assign frame_ovf = ovf_q;
endmodule
